// File: rtl/lc3_mem_arbiter.sv
// Arbitrates one single-port unified memory between LC3 instruction fetch and data access.
// Data has priority, a starvation limit guarantees fetch progress, and a timeout aborts hung accesses.
module lc3_mem_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic          clock,
    input  logic          reset,
    // Request/complete handshake: a requester raises x_req and holds it until the
    // one-cycle x_done pulse; the memory side holds mem_req and all mem_* stable
    // until a one-cycle mem_ack (or the timeout) ends the access.
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    input  logic          d_req,
    input  logic          d_rd,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          err,
    output logic [1:0]    dbg_state
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          i_done_q, i_done_d;
    logic          d_done_q, d_done_d;
    logic          err_q, err_d;

    logic          done_cycle;
    logic          i_elig;
    logic          d_elig;

    // The cycle carrying a done pulse is a turnaround: the finishing requester
    // still shows its req, so nothing is granted until the next cycle.
    assign done_cycle = i_done_q | d_done_q;
    assign i_elig     = i_req & ~done_cycle;
    assign d_elig     = d_req & ~done_cycle;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                tmo_d     = '0;
                mem_req_d = 1'b0;
                if (d_elig && !(i_elig && starve_q == STARVE_MAX)) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ~d_rd;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    if (i_elig && starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (i_elig) begin
                    state_d    = BUSY_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = i_addr;
                    starve_d   = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    tmo_d     = '0;
                    if (state_q == BUSY_I) begin
                        i_done_d  = 1'b1;
                        i_rdata_d = mem_rdata;
                    end else begin
                        d_done_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Abort: the requester still gets its done, with zero data.
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    tmo_d     = '0;
                    err_d     = 1'b1;
                    if (state_q == BUSY_I) begin
                        i_done_d  = 1'b1;
                        i_rdata_d = '0;
                    end else begin
                        d_done_d  = 1'b1;
                        d_rdata_d = '0;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        if (!i_req) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: reset, fetch, priority, starvation, timeout,
// mid-transaction reset, then a table of single transactions with hand-computed results.
module tb_lc3_mem_arbiter;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY_I = 2'd1;
    localparam logic [1:0] S_BUSY_D = 2'd2;

    logic        clock;
    logic        reset;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_rdata;
    logic        i_done;
    logic        d_req;
    logic        d_rd;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        err;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    lc3_mem_arbiter #(
        .AW(16), .DW(16), .STARVE_LIMIT(4), .TIMEOUT(64)
    ) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_rd(d_rd), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .err(err), .dbg_state(dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        is_d;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] mrd;
        int          wait_n;
        logic        exp_we;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_mem_req(input string name);
        int k;
        k = 0;
        while (mem_req !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check(name, 64'(mem_req), 64'd1);
    endtask

    // Protocol invariants watched every cycle outside reset.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            checks++;
            if (i_done && d_done) begin
                errors++;
                $display("FAIL dual_done: i_done=%b d_done=%b required not both", i_done, d_done);
            end
            if (mem_req && dbg_state == S_IDLE) begin
                errors++;
                $display("FAIL req_in_idle: mem_req=%b state=%0d", mem_req, dbg_state);
            end
        end
    end

    initial begin
        int n_d;
        logic found_i;
        int k;

        vecs[0] = '{1'b0, 1'b1, 16'h3000, 16'h0000, 16'h1111, 0, 1'b0, 16'h1111};
        vecs[1] = '{1'b1, 1'b1, 16'h4000, 16'h0000, 16'hA5A5, 1, 1'b0, 16'hA5A5};
        vecs[2] = '{1'b1, 1'b0, 16'h4002, 16'h0F0F, 16'hFFFF, 2, 1'b1, 16'hA5A5};
        vecs[3] = '{1'b0, 1'b1, 16'h3001, 16'h0000, 16'h2222, 3, 1'b0, 16'h2222};
        vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'h8001, 0, 1'b0, 16'h8001};
        vecs[5] = '{1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'h1234, 1, 1'b1, 16'h8001};

        reset = 1'b0; i_req = 1'b1; i_addr = 16'h3000;
        d_req = 1'b0; d_rd = 1'b1; d_addr = 16'h0; d_wdata = 16'h0;
        mem_rdata = 16'hDEAD; mem_ack = 1'b0;

        // 1: reset held with a pending fetch
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_mem_req", 64'(mem_req), 64'd0);
        end
        check("rst_outputs", {mem_we, mem_addr, mem_wdata, i_rdata, i_done, d_rdata, d_done, err, dbg_state}, 64'd0);
        reset = 1'b1;
        tick();
        check("t1_grant_req", 64'(mem_req), 64'd1);
        check("t2_mem_addr", 64'(mem_addr), 64'h3000);
        check("t2_state", 64'(dbg_state), 64'(S_BUSY_I));

        // 2: zero-wait fetch; done one cycle after the ack, no regrant in done cycle
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'hDEAD;
        check("t2_i_done", 64'(i_done), 64'd1);
        check("t2_i_rdata", 64'(i_rdata), 64'h1234);
        tick();
        check("t2_no_regrant", 64'(mem_req), 64'd0);
        check("t2_done_pulse", 64'(i_done), 64'd0);
        i_req = 1'b0;
        tick();
        check("t2_rdata_held", 64'(i_rdata), 64'h1234);

        // 3: simultaneous requests, data write first then fetch
        i_req = 1'b1; i_addr = 16'h3002;
        d_req = 1'b1; d_rd = 1'b0; d_addr = 16'h4000; d_wdata = 16'hBEEF;
        tick();
        check("t3_d_first", 64'(dbg_state), 64'(S_BUSY_D));
        check("t3_mem_we", 64'(mem_we), 64'd1);
        check("t3_mem_addr", 64'(mem_addr), 64'h4000);
        check("t3_mem_wdata", 64'(mem_wdata), 64'hBEEF);
        tick();
        check("t3_req_held", {mem_req, mem_addr}, {1'b1, 16'h4000});
        mem_ack = 1'b1; mem_rdata = 16'h5555;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'hDEAD;
        check("t3_d_done", {d_done, i_done}, {1'b1, 1'b0});
        check("t3_wr_no_rdata", 64'(d_rdata), 64'h0000);
        d_req = 1'b0;
        wait_mem_req("t3_fetch_req");
        check("t3_fetch", {dbg_state, mem_we, mem_addr}, {S_BUSY_I, 1'b0, 16'h3002});
        mem_ack = 1'b1; mem_rdata = 16'h5678;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'hDEAD;
        check("t3_i_rdata", {i_done, i_rdata}, {1'b1, 16'h5678});
        i_req = 1'b0;
        tick();

        // 4: continuous data reads starve fetch for exactly four grants
        i_req = 1'b1; i_addr = 16'h3200;
        d_req = 1'b1; d_rd = 1'b1; d_addr = 16'h4200;
        n_d = 0; found_i = 1'b0;
        for (int t = 0; t < 8 && !found_i; t++) begin
            wait_mem_req("t4_req");
            if (dbg_state == S_BUSY_I) begin
                found_i = 1'b1;
            end else begin
                n_d++;
                mem_rdata = 16'hD000 | 16'(t);
                mem_ack = 1'b1;
                tick();
                mem_ack = 1'b0; mem_rdata = 16'hDEAD;
            end
        end
        check("t4_fetch_won", 64'(found_i), 64'd1);
        check("t4_data_grants", 64'(n_d), 64'd4);
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'hDEAD;
        check("t4_i_rdata", {i_done, i_rdata}, {1'b1, 16'h7777});
        check("t4_d_rdata", 64'(d_rdata), 64'hD003);
        i_req = 1'b0; d_req = 1'b0;
        tick();

        // 5: no ack -> abort after 64 request cycles
        i_req = 1'b1; i_addr = 16'h3100;
        tick();
        k = 0;
        while (mem_req === 1'b1 && k < 100) begin
            k++;
            tick();
        end
        check("t5_req_cycles", 64'(k), 64'd64);
        check("t5_abort", {i_done, i_rdata, err}, {1'b1, 16'h0000, 1'b1});
        i_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'h9999;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'hDEAD;
        check("t5_late_ack", {i_done, mem_req, i_rdata, err}, {1'b0, 1'b0, 16'h0000, 1'b1});
        tick();
        check("t5_err_sticky", 64'(err), 64'd1);

        // 6: async reset in the middle of a data read
        d_req = 1'b1; d_rd = 1'b1; d_addr = 16'h4100;
        tick();
        check("t6_busy_d", {mem_req, dbg_state}, {1'b1, S_BUSY_D});
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_drop", {mem_req, dbg_state, err, d_done}, {1'b0, S_IDLE, 1'b0, 1'b0});
        mem_ack = 1'b1; mem_rdata = 16'hAAAA;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'hDEAD;
        check("t6_no_d_done", {d_done, d_rdata}, {1'b0, 16'h0000});
        d_req = 1'b0;
        reset = 1'b1;
        tick();
        check("t6_after_release", {d_done, mem_req, dbg_state}, {1'b0, 1'b0, S_IDLE});

        // Table: one transaction per record
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].is_d) begin
                d_req = 1'b1; d_rd = vecs[v].rd; d_addr = vecs[v].addr; d_wdata = vecs[v].wdata;
            end else begin
                i_req = 1'b1; i_addr = vecs[v].addr;
            end
            wait_mem_req($sformatf("v%0d_req", v));
            check($sformatf("v%0d_addr", v), 64'(mem_addr), 64'(vecs[v].addr));
            check($sformatf("v%0d_we", v), 64'(mem_we), 64'(vecs[v].exp_we));
            if (vecs[v].exp_we) begin
                check($sformatf("v%0d_wdata", v), 64'(mem_wdata), 64'(vecs[v].wdata));
            end
            for (int w = 0; w < vecs[v].wait_n; w++) begin
                tick();
            end
            check($sformatf("v%0d_held", v), {mem_req, mem_addr}, {1'b1, vecs[v].addr});
            mem_ack = 1'b1; mem_rdata = vecs[v].mrd;
            tick();
            mem_ack = 1'b0; mem_rdata = 16'hDEAD;
            if (vecs[v].is_d) begin
                check($sformatf("v%0d_done", v), {d_done, i_done, d_rdata}, {1'b1, 1'b0, vecs[v].exp_rdata});
            end else begin
                check($sformatf("v%0d_done", v), {i_done, d_done, i_rdata}, {1'b1, 1'b0, vecs[v].exp_rdata});
            end
            i_req = 1'b0; d_req = 1'b0;
            tick();
            check($sformatf("v%0d_pulse", v), {i_done, d_done, mem_req}, 64'd0);
        end
        check("final_err_clear", 64'(err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
